// File: rtl/instruction_loader_pkg.sv
// Shared types and constants for the instruction loader and its byte packer.
package instruction_loader_pkg;

    localparam int unsigned INSTR_WIDTH    = 32;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRecv  = 2'd1,
        StWrite = 2'd2,
        StDone  = 2'd3
    } state_e;

endpackage

// File: rtl/instruction_loader_byte_packer.sv
// Assembles incoming bytes into little-endian instruction words and flags the
// transfer that completes a word.
module instruction_loader_byte_packer
    import instruction_loader_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   clear_i,
    input  logic                   accept_i,
    input  logic [7:0]             byte_i,
    output logic [INSTR_WIDTH-1:0] word_o,
    output logic                   word_complete_o
);

    logic [BYTE_IDX_W-1:0]  byte_count_q, byte_count_d;
    logic [INSTR_WIDTH-1:0] word_q, word_d;

    always_comb begin
        byte_count_d = byte_count_q;
        word_d       = word_q;
        if (clear_i) begin
            byte_count_d = '0;
            word_d       = '0;
        end else if (accept_i) begin
            word_d[8*byte_count_q +: 8] = byte_i;
            byte_count_d                = byte_count_q + 1'b1;
        end
    end

    // word_o includes the byte being accepted so the completing transfer
    // can be latched by the parent in the same cycle.
    assign word_o          = word_d;
    assign word_complete_o = accept_i && !clear_i &&
                             (byte_count_q == BYTE_IDX_W'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            byte_count_q <= '0;
            word_q       <= '0;
        end else begin
            byte_count_q <= byte_count_d;
            word_q       <= word_d;
        end
    end

endmodule

// File: rtl/instruction_loader.sv
// Loads a byte stream into instruction memory one 32-bit word at a time while
// holding the core stalled.
module instruction_loader
    import instruction_loader_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH  = 64,
    parameter int unsigned           DEPTH_WORDS = 64,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [15:0]            num_words,
    input  logic                   byte_valid,
    input  logic [7:0]             byte_data,
    output logic                   byte_ready,
    output logic                   mem_we,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    output logic [INSTR_WIDTH-1:0] mem_wdata,
    output logic                   cpu_hold,
    output logic                   busy,
    output logic                   done,
    output logic                   error
);

    state_e                 state_q, state_d;
    logic [15:0]            num_words_q, num_words_d;
    logic [15:0]            word_idx_q, word_idx_d;
    logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
    logic [INSTR_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                   error_q, error_d;
    logic                   packer_clear;
    logic                   word_complete;
    logic [INSTR_WIDTH-1:0] packed_word;

    instruction_loader_byte_packer u_byte_packer (
        .clk_i           (clk),
        .reset_i         (reset),
        .clear_i         (packer_clear),
        .accept_i        (byte_valid && byte_ready),
        .byte_i          (byte_data),
        .word_o          (packed_word),
        .word_complete_o (word_complete)
    );

    always_comb begin
        state_d      = state_q;
        num_words_d  = num_words_q;
        word_idx_d   = word_idx_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        error_d      = error_q;
        packer_clear = 1'b0;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    packer_clear = 1'b1;
                    error_d      = 1'b0;
                    num_words_d  = num_words;
                    word_idx_d   = '0;
                    if (num_words == 16'd0) begin
                        state_d = StDone;
                    end else if (32'(num_words) > DEPTH_WORDS) begin
                        error_d = 1'b1;
                        state_d = StDone;
                    end else begin
                        state_d = StRecv;
                    end
                end
            end
            StRecv: begin
                if (word_complete) begin
                    mem_addr_d  = BASE_ADDR + (ADDR_WIDTH'(word_idx_q) << 2);
                    mem_wdata_d = packed_word;
                    state_d     = StWrite;
                end
            end
            StWrite: begin
                word_idx_d = word_idx_q + 16'd1;
                state_d    = (word_idx_q + 16'd1 == num_words_q) ? StDone : StRecv;
            end
            default: state_d = StIdle;
        endcase
    end

    assign byte_ready = (state_q == StRecv);
    assign mem_we     = (state_q == StWrite);
    assign busy       = (state_q == StRecv) || (state_q == StWrite);
    assign cpu_hold   = busy;
    assign done       = (state_q == StDone);
    assign error      = error_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            num_words_q <= '0;
            word_idx_q  <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            num_words_q <= num_words_d;
            word_idx_q  <= word_idx_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            error_q     <= error_d;
        end
    end

endmodule

// File: tb/tb_instruction_loader.sv
// Scoreboard bench for instruction_loader: directed byte streams, expected
// writes queued at issue time and checked by an independent monitor.
module tb_instruction_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] num_words;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        error;

    typedef struct {
        logic [63:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   bytes_sent = 0;
    int   writes_load = 0;
    bit   hold_seen = 0;
    bit   we_seen = 0;

    logic [7:0] nominal [12] = '{8'h33, 8'h00, 8'h00, 8'h00,
                                 8'h33, 8'h05, 8'hA5, 8'h00,
                                 8'h33, 8'h85, 8'h05, 8'h40};

    instruction_loader #(
        .ADDR_WIDTH  (64),
        .DEPTH_WORDS (64),
        .BASE_ADDR   (64'd0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .num_words  (num_words),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push_exp(input logic [63:0] a, input logic [31:0] d);
        exp_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic push_nominal();
        push_exp(64'd0, 32'h0000_0033);
        push_exp(64'd4, 32'h00A5_0533);
        push_exp(64'd8, 32'h4005_8533);
    endtask

    // Called just after a rising edge; leaves the bench just after a rising edge.
    task automatic do_start(input logic [15:0] n);
        bytes_sent  = 0;
        writes_load = 0;
        start       = 1'b1;
        num_words   = n;
        @(posedge clk);
        #1;
        start     = 1'b0;
        num_words = 16'd0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) @(posedge clk);
        #1;
        byte_valid = 1'b1;
        byte_data  = b;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (byte_ready) begin
                @(posedge clk);
                #1;
                byte_valid = 1'b0;
                bytes_sent++;
                return;
            end
        end
        check("byte_accept_timeout", {63'd0, byte_ready}, 64'd1);
        byte_valid = 1'b0;
    endtask

    task automatic send_nominal(input int first, input int last, input bit random_gaps);
        for (int i = first; i <= last; i++)
            send_byte(nominal[i], random_gaps ? int'($urandom_range(0, 7)) : 0);
    endtask

    task automatic wait_done(input logic exp_err);
        int n;
        n = 0;
        while (!done && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("done", {63'd0, done}, 64'd1);
        check("error", {63'd0, error}, {63'd0, exp_err});
        check("cpu_hold_released", {63'd0, cpu_hold}, 64'd0);
        check("busy_released", {63'd0, busy}, 64'd0);
        check("all_writes_seen", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: every write is matched against the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (cpu_hold) hold_seen = 1'b1;
        if (cpu_hold !== busy) check("busy_eq_hold", {63'd0, busy}, {63'd0, cpu_hold});
        if (mem_we) begin
            we_seen = 1'b1;
            check("ready_low_in_write", {63'd0, byte_ready}, 64'd0);
            check("bytes_before_write", 64'(bytes_sent), 64'(4 * (writes_load + 1)));
            if (exp_q.size() == 0) begin
                check("write_expected", 64'(exp_q.size()), 64'd1);
            end else begin
                e = exp_q.pop_front();
                check("mem_addr", mem_addr, e.addr);
                check("mem_wdata", {32'd0, mem_wdata}, {32'd0, e.data});
            end
            writes_load++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        num_words  = 16'd0;
        byte_valid = 1'b0;
        byte_data  = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_we", {63'd0, mem_we}, 64'd0);
        check("rst_mem_addr", mem_addr, 64'd0);
        check("rst_mem_wdata", {32'd0, mem_wdata}, 64'd0);
        check("rst_outputs", {58'd0, byte_ready, cpu_hold, busy, done, error, mem_we}, 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Nominal back-to-back load
        push_nominal();
        do_start(16'd3);
        check("hold_after_start", {62'd0, cpu_hold, busy}, 64'd3);
        send_nominal(0, 11, 1'b0);
        wait_done(1'b0);

        // Same stream with random idle gaps
        push_nominal();
        do_start(16'd3);
        send_nominal(0, 11, 1'b1);
        wait_done(1'b0);

        // Zero-length load
        hold_seen = 1'b0;
        we_seen   = 1'b0;
        do_start(16'd0);
        check("zero_done_next_cycle", {62'd0, done, error}, 64'd2);
        repeat (4) @(posedge clk);
        #1;
        check("zero_no_hold", {63'd0, hold_seen}, 64'd0);
        check("zero_no_write", {63'd0, we_seen}, 64'd0);

        // Oversized load, then recovery
        do_start(16'd65);
        check("oversize_flags", {62'd0, done, error}, 64'd3);
        repeat (4) @(posedge clk);
        #1;
        check("oversize_no_hold", {63'd0, hold_seen}, 64'd0);
        check("oversize_no_write", {63'd0, we_seen}, 64'd0);
        push_exp(64'd0, 32'h0000_0013);
        do_start(16'd1);
        check("error_cleared", {63'd0, error}, 64'd0);
        send_byte(8'h13, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        wait_done(1'b0);

        // Reset after 6 bytes of a 2-word load
        push_exp(64'd0, 32'h0000_0033);
        do_start(16'd2);
        send_nominal(0, 5, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_outputs", {58'd0, byte_ready, cpu_hold, busy, done, error, mem_we}, 64'd0);
        check("midrst_mem_addr", mem_addr, 64'd0);
        check("midrst_mem_wdata", {32'd0, mem_wdata}, 64'd0);
        check("midrst_first_word_written", 64'(exp_q.size()), 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        push_nominal();
        do_start(16'd3);
        send_nominal(0, 11, 1'b0);
        wait_done(1'b0);

        // Start pulsed mid-load must be ignored
        push_nominal();
        do_start(16'd3);
        send_nominal(0, 4, 1'b0);
        start     = 1'b1;
        num_words = 16'd1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        num_words = 16'd0;
        check("start_ignored_busy", {63'd0, busy}, 64'd1);
        send_nominal(5, 11, 1'b1);
        wait_done(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
